// File: rtl/serial_word_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_queue_pkg
// Description : Shared types and helpers for the serial word queue.
//               - bit_order_e : placement of the first received serial bit
//               - count_width : width of an occupancy counter for a FIFO of
//                               the given depth (must represent 0..depth)
// Revision    : 1.0 - initial release
// ============================================================================
package serial_word_queue_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,  // first bit ends up in bit WIDTH-1
    LSB_FIRST = 1'b1   // first bit ends up in bit 0
  } bit_order_e;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular-buffer FIFO, first-word-fall-through.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, push_data - write request and word
//               pop             - read request (ignored when empty)
//               head_data       - head word, 0 when empty
//               empty, full     - status
//               count           - occupancy 0..DEPTH
//               drop            - push refused because full with no pop
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import serial_word_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          empty,
  output logic                          full,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_COUNT);
  assign count = cnt;

  // A pop from a full FIFO frees the slot the simultaneous push needs.
  // When empty, the pop is suppressed and only the push lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  // Head is a function of registered state only.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CW'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage carries no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_word_queue.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_queue
// Description : Serial-to-parallel word assembler feeding a synchronous FIFO,
//               with sticky overflow flag and partial-word flush.
// Ports       : clk, rst_n       - clock, async active-low reset
//               data_in,write_in - serial bit and its strobe
//               flush_in         - drop partial word, clear overflow
//               dequeue_in       - pop head word
//               queue_data_out   - head word (0 when empty)
//               queue_empty_out, queue_full_out, queue_count_out
//               bit_count_out    - bits held in the partial word
//               overflow_out     - sticky: a completed word was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_queue
  import serial_word_queue_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         DEPTH     = 4,
  parameter bit_order_e BIT_ORDER = MSB_FIRST
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_in,
  input  logic                          write_in,
  input  logic                          flush_in,
  input  logic                          dequeue_in,
  output logic [WIDTH-1:0]              queue_data_out,
  output logic                          queue_empty_out,
  output logic                          queue_full_out,
  output logic [count_width(DEPTH)-1:0] queue_count_out,
  output logic [$clog2(WIDTH)-1:0]      bit_count_out,
  output logic                          overflow_out
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic [BCW-1:0]   bit_cnt;
  logic             overflow;
  logic             take_bit;
  logic             word_done;
  logic             fifo_drop;

  // A flush in the same cycle swallows the strobed bit.
  assign take_bit  = write_in && !flush_in;
  assign word_done = take_bit && (bit_cnt == LAST_BIT);

  // next_word includes the current bit, so a completing strobe pushes the
  // whole word in the same cycle.
  generate
    if (BIT_ORDER == MSB_FIRST) begin : g_msb_first
      assign next_word = {shift_reg[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign next_word = {data_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (flush_in) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (take_bit) begin
      shift_reg <= word_done ? '0 : next_word;
      bit_cnt   <= word_done ? '0 : bit_cnt + BCW'(1);
    end
  end

  // Flush and push are mutually exclusive, so clear and set never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush_in) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (word_done),
    .push_data (next_word),
    .pop       (dequeue_in),
    .head_data (queue_data_out),
    .empty     (queue_empty_out),
    .full      (queue_full_out),
    .count     (queue_count_out),
    .drop      (fifo_drop)
  );

  assign bit_count_out = bit_cnt;
  assign overflow_out  = overflow;

endmodule
`default_nettype wire
